imem_fetch_seq: RTL and testbench
=================================

IMEM_FETCH_SEQ -- requirements
Module: imem_fetch_seq

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width.
REQ-002 Parameter DEPTH, default 16, instruction memory entries; a power of two, at least 2; AW = clog2(DEPTH).
REQ-003 Parameter ICODE_HALT, default 4'h0, the opcode in instr[DATA_W-1:DATA_W-4] that ends a run.
REQ-004 Port clock, input, 1, system clock; all logic is on the rising edge.
REQ-005 One clock; reset is synchronous and active-low; the reset port is resetn, input, 1.
REQ-006 Port addr, input, AW, load/readback address.
REQ-007 Port wr, input, 1, write strobe for program load.
REQ-008 Port wdata, input, DATA_W, program word.
REQ-009 Port working, input, 1, run enable (level).
REQ-010 Port step_mode, input, 1, 1 = single-step execution.
REQ-011 Port step, input, 1, one-cycle pulse that releases one instruction in PAUSE.
REQ-012 Port bp_en, input, 1, breakpoint enable.
REQ-013 Port bp_addr, input, AW, breakpoint PC.
REQ-014 Port stall, input, 1, downstream back-pressure.
REQ-015 Port instr, output, DATA_W, issued instruction.
REQ-016 Port instr_valid, output, 1, instr is valid this cycle.
REQ-017 Port pc, output, AW, next fetch address.
REQ-018 Port state, output, 2, FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-019 Port rdata, output, DATA_W, registered readback of mem[addr].
REQ-020 Port prog_len, output, AW+1, highest written address + 1.

Function
REQ-021 In IDLE, wr=1 SHALL write wdata to mem[addr] and set prog_len to max(prog_len, addr+1) at the next edge.
REQ-022 In any state other than IDLE, wr SHALL be ignored.
REQ-023 rdata SHALL equal mem[addr] one cycle after addr is presented, in every state.
REQ-024 IDLE->RUN on working=1; pc is cleared to 0 at the same edge.
REQ-025 In RUN with stall=0, the block SHALL register instr=mem[pc] with instr_valid=1 and increment pc; latency is 1 cycle from the RUN edge.
REQ-026 With stall=1, instr, instr_valid and pc SHALL hold their values.
REQ-027 If bp_en=1 and pc==bp_addr, RUN SHALL go to PAUSE without issuing; the breakpoint fires once per arrival at that pc.
REQ-028 With step_mode=1, RUN SHALL issue exactly one instruction, then go to PAUSE.
REQ-029 In PAUSE, instr_valid SHALL be 0.
REQ-030 In PAUSE, step=1 SHALL issue mem[pc] and then return to PAUSE if step_mode=1, otherwise go to RUN.
REQ-031 step and stall asserted together SHALL NOT issue; the step is held pending until stall=0.
REQ-032 Fetching an instruction whose opcode equals ICODE_HALT SHALL go to DONE without issuing that word.
REQ-033 Reaching pc==prog_len SHALL go to DONE.
REQ-034 When pc reaches DEPTH, it SHALL wrap to 0 and the block SHALL go to DONE.
REQ-035 In DONE, instr_valid SHALL be 0 and pc SHALL hold.
REQ-036 working=0 in any state SHALL return the block to IDLE at the next edge and clear instr_valid; memory contents are preserved.
REQ-037 working=0 takes priority over step, breakpoint and halt in the same cycle.

Reset
REQ-038 resetn=0 at a rising edge SHALL give state=IDLE, pc=0, instr=0, instr_valid=0, rdata=0, prog_len=0 and clear the pending step.
REQ-039 Memory contents are not reset.
REQ-040 Reset mid-run SHALL abort the run with no further issue.

Structure
REQ-041 The state encodings and the ICODE_HALT default SHALL live in a shared package, proc_pkg.
REQ-042 The storage SHALL be one sub-module, imem_ram: a single write port plus two synchronous read ports (fetch and readback).

Verification
REQ-043 Load 10F00090..10F70097 at addresses 0..7, then working=1 -> 8 consecutive instr_valid pulses with instr matching the loaded words in order, then state=DONE at pc=8.
REQ-044 Same program with bp_en=1, bp_addr=3 -> words 0..2 issued, then state=PAUSE with pc=3; step -> 10F30093 issued, then RUN continues to the end.
REQ-045 step_mode=1 -> no issue without step; each step pulse yields exactly one instr_valid; step together with stall=1 -> issue deferred until stall=0.
REQ-046 Word 00000000 loaded at address 5 -> words 0..4 issued, then DONE with pc=5.
REQ-047 working dropped at cycle 3 of RUN -> IDLE next cycle; a wr during RUN does not alter memory (readback unchanged).
REQ-048 DEPTH=4 with all 4 entries loaded -> 4 issues, then pc wraps to 0 and state=DONE; resetn=0 mid-run -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_e        : sequencer FSM states, encoded as seen on the state port.
//   ICODE_HALT_DEF : default opcode (top nibble of a word) that ends a run.
//   OPC_W          : width of the opcode field at the top of each word.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0]  ICODE_HALT_DEF = 4'h0;
  localparam int unsigned OPC_W          = 4;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port and two synchronous read ports.
//   clock, resetn   : clock and synchronous active-low reset (readback only)
//   we_i/waddr_i/wdata_i : program load port
//   faddr_i/fdata_o : fetch port, data registered at the clock edge
//   raddr_i/rdata_o : readback port, data registered at the clock edge
// Reads are read-first: a read of the address being written returns old data.
module imem_ram #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     faddr_i,
  output logic [DATA_W-1:0] fdata_o,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] fdata_q;
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; a reset loop
  // over every entry would force it into flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The fetch register is internal pipeline data; its value before the first
  // issue is never used, so it carries no reset.
  always_ff @(posedge clock) begin
    fdata_q <= mem_q[faddr_i];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign fdata_o = fdata_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_seq.sv
// Instruction fetch sequencer with program load, breakpoint and single-step.
//   clock, resetn      : clock, synchronous active-low reset
//   addr, wr, wdata    : program load (IDLE only) and readback address
//   working            : run enable level; low returns to IDLE
//   step_mode, step    : single-step control; step releases one word in PAUSE
//   bp_en, bp_addr     : breakpoint on fetch address
//   stall              : downstream back-pressure, freezes issue outputs
//   instr, instr_valid : issued word and its qualifier
//   pc                 : next fetch address
//   state              : FSM state (IDLE/RUN/PAUSE/DONE)
//   rdata              : registered mem[addr]
//   prog_len           : highest written address + 1
module imem_fetch_seq
  import proc_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned DEPTH      = 16,
  parameter  logic [3:0]  ICODE_HALT = ICODE_HALT_DEF,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [AW-1:0]     addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              working,
  input  logic              step_mode,
  input  logic              step,
  input  logic              bp_en,
  input  logic [AW-1:0]     bp_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [AW-1:0]     pc,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0]       prog_len
);

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic              step_pend_q, step_pend_d;
  // Set when pc wrapped past DEPTH-1; prog_len can equal DEPTH, which an
  // AW-bit pc never matches, so the wrap is remembered explicitly.
  logic              wrap_q, wrap_d;

  logic              mem_we;
  logic [AW:0]       len_cand;
  logic [DATA_W-1:0] fetch_data;
  logic              at_end, is_halt, bp_hit, step_req, do_issue;

  // The fetch port is addressed with pc_d, so during any cycle fetch_data
  // already holds mem[pc_q] and halt detection needs no extra cycle.
  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock   (clock),
    .resetn  (resetn),
    .we_i    (mem_we),
    .waddr_i (addr),
    .wdata_i (wdata),
    .faddr_i (pc_d),
    .fdata_o (fetch_data),
    .raddr_i (addr),
    .rdata_o (rdata)
  );

  assign mem_we   = (state_q == ST_IDLE) && wr;
  assign len_cand = {1'b0, addr} + (AW+1)'(1);
  assign at_end   = wrap_q || ({1'b0, pc_q} == prog_len_q);
  assign is_halt  = (fetch_data[DATA_W-1 -: OPC_W] == ICODE_HALT);
  assign bp_hit   = bp_en && (pc_q == bp_addr);
  assign step_req = step || step_pend_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;
    prog_len_d  = prog_len_q;
    step_pend_d = 1'b0;
    wrap_d      = wrap_q;
    do_issue    = 1'b0;

    if (mem_we && (len_cand > prog_len_q)) begin
      prog_len_d = len_cand;
    end

    if (!working) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          pc_d    = '0;
          wrap_d  = 1'b0;
        end
        ST_RUN: begin
          // valid_q in RUN means a word was issued at the last edge; in
          // step mode that is the one word RUN may issue before parking.
          // The breakpoint cannot re-fire on the same arrival because every
          // exit from PAUSE issues and so moves pc first.
          if (stall) begin
            valid_d = valid_q;
          end else if (at_end) begin
            state_d = ST_DONE;
          end else if (bp_hit) begin
            state_d = ST_PAUSE;
          end else if (step_mode && valid_q) begin
            state_d = ST_PAUSE;
          end else if (is_halt) begin
            state_d = ST_DONE;
          end else begin
            do_issue = 1'b1;
          end
        end
        ST_PAUSE: begin
          // Issue passes through RUN for one cycle so instr_valid is never
          // high while the state reads PAUSE.
          if (step_req) begin
            if (stall) begin
              step_pend_d = 1'b1;
            end else if (at_end || is_halt) begin
              state_d = ST_DONE;
            end else begin
              do_issue = 1'b1;
              state_d  = ST_RUN;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (do_issue) begin
      instr_d = fetch_data;
      valid_d = 1'b1;
      pc_d    = pc_q + 1'b1;
      wrap_d  = (pc_q == AW'(DEPTH - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      prog_len_q  <= '0;
      step_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      prog_len_q  <= prog_len_d;
      step_pend_q <= step_pend_d;
      wrap_q      <= wrap_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_imem_fetch_seq.sv
// Self-checking bench for imem_fetch_seq: a DEPTH=16 instance plus a DEPTH=4
// instance sharing the same stimulus. Expected issue sequences come from a
// program-level model: walk the loaded words from address 0 until prog_len,
// DEPTH or a halt opcode is reached.
module tb_imem_fetch_seq;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  logic        clock = 1'b0;
  logic        resetn, wr, working, step_mode, step, bp_en, stall;
  logic [3:0]  addr, bp_addr;
  logic [31:0] wdata;

  logic [31:0] instr, rdata;
  logic        instr_valid;
  logic [3:0]  pc;
  logic [1:0]  state;
  logic [4:0]  prog_len;

  logic [31:0] instr4, rdata4;
  logic        valid4;
  logic [1:0]  pc4;
  logic [1:0]  state4;
  logic [2:0]  prog_len4;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] model_mem [16];
  int          model_len;
  logic [31:0] exp_q[$];
  logic [31:0] issued_q[$];
  int          issue_cyc[$];

  imem_fetch_seq #(.DATA_W(32), .DEPTH(16)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wr(wr), .wdata(wdata),
    .working(working), .step_mode(step_mode), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .stall(stall), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .state(state), .rdata(rdata), .prog_len(prog_len)
  );

  imem_fetch_seq #(.DATA_W(32), .DEPTH(4)) dut4 (
    .clock(clock), .resetn(resetn), .addr(addr[1:0]), .wr(wr), .wdata(wdata),
    .working(working), .step_mode(step_mode), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr[1:0]), .stall(stall), .instr(instr4), .instr_valid(valid4),
    .pc(pc4), .state(state4), .rdata(rdata4), .prog_len(prog_len4)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; working = 1'b0; wr = 1'b0; step = 1'b0; stall = 1'b0;
    step_mode = 1'b0; bp_en = 1'b0; addr = '0; bp_addr = '0; wdata = '0;
    tick();
    resetn = 1'b1;
    model_len = 0;
    issued_q.delete();
    issue_cyc.delete();
  endtask

  task automatic load_word(input int a, input logic [31:0] w);
    addr = 4'(a); wdata = w; wr = 1'b1;
    tick();
    wr = 1'b0;
    model_mem[a] = w;
    if (a + 1 > model_len) model_len = a + 1;
  endtask

  task automatic load_demo();
    for (int i = 0; i < 8; i++) load_word(i, 32'h10F00090 + 32'h00010001 * i);
  endtask

  // Program-level reference: issue words from 0 until the end of the
  // program, the end of memory, or a halt opcode; pc stops there (mod depth).
  function automatic int model_expect(input int len, input int depth);
    int i = 0;
    exp_q.delete();
    while (i < len && i < depth && model_mem[i][31:28] != 4'h0) begin
      exp_q.push_back(model_mem[i]);
      i++;
    end
    return i % depth;
  endfunction

  // Clock until the chosen instance reaches stop_st; a word counts as newly
  // issued when instr_valid is high after an edge at which stall was low.
  task automatic run_until(input logic [1:0] stop_st, input int budget,
                           input int stall_pct, input bit use4, output bit reached);
    reached = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bit st_e;
      stall = ($urandom_range(0, 99) < stall_pct);
      st_e  = stall;
      tick();
      if (!use4 && instr_valid && !st_e) begin issued_q.push_back(instr); issue_cyc.push_back(c); end
      if (use4 && valid4 && !st_e) begin issued_q.push_back(instr4); issue_cyc.push_back(c); end
      if ((use4 ? state4 : state) == stop_st) begin reached = 1'b1; break; end
    end
    stall = 1'b0;
  endtask

  task automatic cmp_issued(input string name);
    vectors++;
    if (issued_q.size() !== exp_q.size()) begin
      $display("FAIL %s count: got %0d expected %0d", name, issued_q.size(), exp_q.size());
      miscompares++;
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (issued_q[i] !== exp_q[i]) begin
          $display("FAIL %s word%0d: got %h expected %h", name, i, issued_q[i], exp_q[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state !== S_IDLE) begin $display("FAIL reset state: got %0d expected 0", state); miscompares++; end
    vectors++; if (pc !== 4'd0) begin $display("FAIL reset pc: got %0d expected 0", pc); miscompares++; end
    vectors++; if (instr !== 32'd0) begin $display("FAIL reset instr: got %h expected 0", instr); miscompares++; end
    vectors++; if (instr_valid !== 1'b0) begin $display("FAIL reset valid: got %b expected 0", instr_valid); miscompares++; end
    vectors++; if (rdata !== 32'd0) begin $display("FAIL reset rdata: got %h expected 0", rdata); miscompares++; end
    vectors++; if (prog_len !== 5'd0) begin $display("FAIL reset prog_len: got %0d expected 0", prog_len); miscompares++; end
  endtask

  task automatic test_load_readback();
    do_reset();
    load_demo();
    vectors++; if (prog_len !== 5'd8) begin $display("FAIL load prog_len: got %0d expected 8", prog_len); miscompares++; end
    for (int i = 7; i >= 0; i--) begin
      addr = 4'(i);
      tick();
      vectors++;
      if (rdata !== model_mem[i]) begin $display("FAIL readback addr%0d: got %h expected %h", i, rdata, model_mem[i]); miscompares++; end
    end
  endtask

  task automatic test_sequential_run();
    bit reached;
    int exp_pc;
    do_reset();
    load_demo();
    exp_pc = model_expect(model_len, 16);
    working = 1'b1;
    run_until(S_DONE, 40, 0, 1'b0, reached);
    vectors++; if (!reached) begin $display("FAIL seq done: state %0d never reached DONE", state); miscompares++; end
    cmp_issued("seq");
    vectors++;
    if (issue_cyc.size() == 8 && issue_cyc[7] - issue_cyc[0] !== 7) begin
      $display("FAIL seq contiguous: span %0d expected 7", issue_cyc[7] - issue_cyc[0]); miscompares++;
    end
    vectors++; if (pc !== 4'(exp_pc)) begin $display("FAIL seq pc: got %0d expected %0d", pc, exp_pc); miscompares++; end
    vectors++; if (instr_valid !== 1'b0) begin $display("FAIL seq done valid: got %b expected 0", instr_valid); miscompares++; end
  endtask

  task automatic test_breakpoint();
    bit reached;
    do_reset();
    load_demo();
    bp_en = 1'b1; bp_addr = 4'd3; working = 1'b1;
    run_until(S_PAUSE, 40, 0, 1'b0, reached);
    vectors++; if (!reached) begin $display("FAIL bp pause: state %0d never reached PAUSE", state); miscompares++; end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(model_mem[i]);
    cmp_issued("bp_pre");
    vectors++; if (pc !== 4'd3) begin $display("FAIL bp pc: got %0d expected 3", pc); miscompares++; end
    repeat (3) tick();
    vectors++; if (instr_valid !== 1'b0 || state !== S_PAUSE) begin
      $display("FAIL bp hold: valid %b state %0d expected 0/2", instr_valid, state); miscompares++; end
    step = 1'b1; tick(); step = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr !== 32'h10F30093) begin
      $display("FAIL bp step: valid %b instr %h expected 1/10f30093", instr_valid, instr); miscompares++; end
    issued_q.delete();
    run_until(S_DONE, 40, 0, 1'b0, reached);
    exp_q.delete();
    for (int i = 4; i < 8; i++) exp_q.push_back(model_mem[i]);
    cmp_issued("bp_post");
    vectors++; if (!reached || pc !== 4'd8) begin $display("FAIL bp end: reached %b pc %0d expected 1/8", reached, pc); miscompares++; end
  endtask

  task automatic test_step_mode();
    bit reached;
    do_reset();
    load_demo();
    step_mode = 1'b1; working = 1'b1;
    run_until(S_PAUSE, 20, 0, 1'b0, reached);
    exp_q.delete(); exp_q.push_back(model_mem[0]);
    cmp_issued("step_first");
    issued_q.delete();
    run_until(S_DONE, 6, 0, 1'b0, reached);
    vectors++; if (issued_q.size() !== 0) begin $display("FAIL step idle: got %0d issues expected 0", issued_q.size()); miscompares++; end
    step = 1'b1; tick(); step = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr !== model_mem[1]) begin
      $display("FAIL step one: valid %b instr %h expected 1/%h", instr_valid, instr, model_mem[1]); miscompares++; end
    tick();
    vectors++; if (instr_valid !== 1'b0 || state !== S_PAUSE) begin
      $display("FAIL step repark: valid %b state %0d expected 0/2", instr_valid, state); miscompares++; end
    step = 1'b1; stall = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (instr_valid !== 1'b0) begin $display("FAIL step stalled%0d: valid %b expected 0", i, instr_valid); miscompares++; end
      tick();
    end
    stall = 1'b0; tick();
    vectors++; if (instr_valid !== 1'b1 || instr !== model_mem[2]) begin
      $display("FAIL step deferred: valid %b instr %h expected 1/%h", instr_valid, instr, model_mem[2]); miscompares++; end
    tick();
    vectors++; if (state !== S_PAUSE || pc !== 4'd3) begin
      $display("FAIL step final: state %0d pc %0d expected 2/3", state, pc); miscompares++; end
  endtask

  task automatic test_halt();
    bit reached;
    int exp_pc;
    do_reset();
    load_demo();
    load_word(5, 32'h00000000);
    exp_pc = model_expect(model_len, 16);
    working = 1'b1;
    run_until(S_DONE, 40, 0, 1'b0, reached);
    cmp_issued("halt");
    vectors++; if (!reached || pc !== 4'(exp_pc)) begin
      $display("FAIL halt end: reached %b pc %0d expected 1/%0d", reached, pc, exp_pc); miscompares++; end
  endtask

  task automatic test_working_drop();
    do_reset();
    load_demo();
    working = 1'b1;
    tick(); tick();
    addr = 4'd2; wdata = 32'hDEADBEEF; wr = 1'b1;
    tick();
    wr = 1'b0; working = 1'b0;
    tick();
    vectors++; if (state !== S_IDLE || instr_valid !== 1'b0) begin
      $display("FAIL drop idle: state %0d valid %b expected 0/0", state, instr_valid); miscompares++; end
    addr = 4'd2; tick();
    vectors++; if (rdata !== model_mem[2]) begin $display("FAIL drop readback: got %h expected %h", rdata, model_mem[2]); miscompares++; end
    vectors++; if (prog_len !== 5'd8) begin $display("FAIL drop prog_len: got %0d expected 8", prog_len); miscompares++; end
  endtask

  task automatic test_depth4_wrap();
    bit reached;
    int exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) load_word(i, 32'hA0000000 | 32'($urandom_range(0, 32'h0FFFFFFF)));
    exp_pc = model_expect(4, 4);
    working = 1'b1;
    run_until(S_DONE, 30, 0, 1'b1, reached);
    cmp_issued("depth4");
    vectors++; if (!reached || pc4 !== 2'(exp_pc)) begin
      $display("FAIL depth4 wrap: reached %b pc %0d expected 1/%0d", reached, pc4, exp_pc); miscompares++; end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_demo();
    working = 1'b1;
    repeat (4) tick();
    resetn = 1'b0; working = 1'b0;
    tick();
    vectors++; if (state !== S_IDLE || pc !== 4'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || rdata !== 32'd0 || prog_len !== 5'd0) begin
      $display("FAIL midreset dut16: state %0d pc %0d instr %h valid %b rdata %h len %0d expected all 0",
               state, pc, instr, instr_valid, rdata, prog_len); miscompares++; end
    vectors++; if (state4 !== S_IDLE || pc4 !== 2'd0 || instr4 !== 32'd0 || valid4 !== 1'b0 || rdata4 !== 32'd0 || prog_len4 !== 3'd0) begin
      $display("FAIL midreset dut4: state %0d pc %0d instr %h valid %b rdata %h len %0d expected all 0",
               state4, pc4, instr4, valid4, rdata4, prog_len4); miscompares++; end
    resetn = 1'b1;
    tick();
    vectors++; if (instr_valid !== 1'b0) begin $display("FAIL midreset after: valid %b expected 0", instr_valid); miscompares++; end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit reached;
      int len, halt_at, exp_pc;
      do_reset();
      len     = $urandom_range(1, 16);
      halt_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) begin
        logic [31:0] w;
        w = {4'($urandom_range(1, 15)), 28'($urandom)};
        if (i == halt_at) w[31:28] = 4'h0;
        load_word(i, w);
      end
      exp_pc = model_expect(model_len, 16);
      working = 1'b1;
      run_until(S_DONE, 200, 25, 1'b0, reached);
      cmp_issued($sformatf("rand%0d", it));
      vectors++; if (!reached || pc !== 4'(exp_pc)) begin
        $display("FAIL rand%0d end: reached %b pc %0d expected 1/%0d", it, reached, pc, exp_pc); miscompares++; end
    end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_sequential_run();
    test_breakpoint();
    test_step_mode();
    test_halt();
    test_working_drop();
    test_depth4_wrap();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
